// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM state encoding and stall-counter width.
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } hazState_e;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_BUSY = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam int STALL_CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_if.sv
// Pipeline-side view of the hazard controller: operand/destination info in, register enables and flushes out.
`default_nettype none

interface hazard_unit_if;
    import core_pkg::*;

    logic [4:0]             ifIdRs;
    logic [4:0]             ifIdRt;
    logic                   ifIdUsesRt;
    logic                   ifIdBranch;
    logic                   idExMemRead;
    logic                   idExRegW;
    logic [4:0]             idExRd;
    logic                   exMemMemRead;
    logic [4:0]             exMemRd;
    logic                   mduStart;
    logic                   memReq;
    logic                   memReady;

    logic                   pcWrite;
    logic                   ifIdWrite;
    logic                   idExWrite;
    logic                   exMemWrite;
    logic                   idExFlush;
    logic                   exMemFlush;
    logic                   memWbFlush;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stallCycles;

    modport master (
        output ifIdRs, ifIdRt, ifIdUsesRt, ifIdBranch,
        output idExMemRead, idExRegW, idExRd,
        output exMemMemRead, exMemRd,
        output mduStart, memReq, memReady,
        input  pcWrite, ifIdWrite, idExWrite, exMemWrite,
        input  idExFlush, exMemFlush, memWbFlush,
        input  state, stallCycles
    );

    modport slave (
        input  ifIdRs, ifIdRt, ifIdUsesRt, ifIdBranch,
        input  idExMemRead, idExRegW, idExRd,
        input  exMemMemRead, exMemRd,
        input  mduStart, memReq, memReady,
        output pcWrite, ifIdWrite, idExWrite, exMemWrite,
        output idExFlush, exMemFlush, memWbFlush,
        output state, stallCycles
    );

endinterface

`default_nettype wire

// File: rtl/hazard_cmp.sv
// Register-number comparators for the hazards forwarding cannot cover: load-use and ID-stage branch operands.
`default_nettype none

module hazard_cmp (
    input  wire logic [4:0] ifIdRs_i,
    input  wire logic [4:0] ifIdRt_i,
    input  wire logic       ifIdUsesRt_i,
    input  wire logic       ifIdBranch_i,
    input  wire logic       idExMemRead_i,
    input  wire logic       idExRegW_i,
    input  wire logic [4:0] idExRd_i,
    input  wire logic       exMemMemRead_i,
    input  wire logic [4:0] exMemRd_i,
    output logic            loadUse_o,
    output logic            brHaz_o
);

    logic idExHitRs;
    logic idExHitRt;
    logic exMemHit;

    assign idExHitRs = (idExRd_i == ifIdRs_i);
    assign idExHitRt = (idExRd_i == ifIdRt_i);
    // Branches compare both operands, so Rt always counts for them.
    assign exMemHit  = (exMemRd_i == ifIdRs_i) || (exMemRd_i == ifIdRt_i);

    assign loadUse_o = idExMemRead_i && (idExRd_i != 5'd0) &&
                       (idExHitRs || (ifIdUsesRt_i && idExHitRt));

    assign brHaz_o   = ifIdBranch_i &&
                       ((idExRegW_i && (idExRd_i != 5'd0) && (idExHitRs || idExHitRt)) ||
                        (exMemMemRead_i && (exMemRd_i != 5'd0) && exMemHit));

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: freezes or bubbles pipeline registers for load-use,
// branch-operand, multi-cycle MDU and data-memory-wait hazards, and counts stall cycles.
`default_nettype none

module hazard_unit
    import core_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = $clog2(MDU_LAT + 1)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [1:0]       ST_AFTER_START = (MDU_LAT > 1) ? ST_MDU_BUSY : ST_RUN;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic memMiss;
    logic mduFreeze;
    logic loadUse;
    logic brHaz;
    logic cntNz;

    logic pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic idExFlush, exMemFlush, memWbFlush;

    hazard_cmp u_cmp (
        .ifIdRs_i       (hz.ifIdRs),
        .ifIdRt_i       (hz.ifIdRt),
        .ifIdUsesRt_i   (hz.ifIdUsesRt),
        .ifIdBranch_i   (hz.ifIdBranch),
        .idExMemRead_i  (hz.idExMemRead),
        .idExRegW_i     (hz.idExRegW),
        .idExRd_i       (hz.idExRd),
        .exMemMemRead_i (hz.exMemMemRead),
        .exMemRd_i      (hz.exMemRd),
        .loadUse_o      (loadUse),
        .brHaz_o        (brHaz)
    );

    assign cntNz     = (cnt_q != '0);
    assign memMiss   = hz.memReq && !hz.memReady;
    // mduStart only counts in RUN: the op sits in EX holding it high while busy.
    assign mduFreeze = ((state_q == ST_RUN) && hz.mduStart) ||
                       ((state_q == ST_MDU_BUSY) && cntNz);

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;
        memWbFlush = 1'b0;
        if (memMiss) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (mduFreeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemFlush = 1'b1;
        end else if (loadUse || brHaz) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (memMiss) begin
                    state_d = ST_MEM_WAIT;
                    if (hz.mduStart) begin
                        cnt_d = CNT_LOAD;
                    end
                end else if (hz.mduStart) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_AFTER_START;
                end
            end
            ST_MDU_BUSY: begin
                if (memMiss) begin
                    state_d = ST_MEM_WAIT;
                end else if (!cntNz) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // The MDU keeps counting down while the memory stall is in effect.
                if (cntNz) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (!memMiss) begin
                    state_d = cntNz ? ST_MDU_BUSY : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_d = (!pcWrite && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign hz.pcWrite     = pcWrite;
    assign hz.ifIdWrite   = ifIdWrite;
    assign hz.idExWrite   = idExWrite;
    assign hz.exMemWrite  = exMemWrite;
    assign hz.idExFlush   = idExFlush;
    assign hz.exMemFlush  = exMemFlush;
    assign hz.memWbFlush  = memWbFlush;
    assign hz.state       = state_q;
    assign hz.stallCycles = stall_q;

endmodule

`default_nettype wire
